phase_interval_timer: RTL and testbench

//  Interval timer and condition generator for the intersection light controller.

---
 rtl/phase_interval_timer.sv | 150 +++++++++++++++
 tb/tb_phase_interval_timer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_interval_timer.sv
// Interval timer and condition generator for the intersection light controller.
// Times the phase interval selected by s_ic_i in prescaled ticks, debounces the
// east car sensor, and decodes the controller's four branch conditions.
// Optional feature: define EMERG_PREEMPT_EN to let a synchronized emerg_i
// truncate the north/east green intervals (codes 10/11).
module phase_interval_timer #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned T_YEL     = 5,
   parameter int unsigned T_CLR     = 2,
   parameter int unsigned T_NGMIN   = 10,
   parameter int unsigned T_EGMAX   = 8,
   parameter int unsigned DEB_TICKS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic [1:0]       s_ic_i,
   input  logic             en_ic_i,
   input  logic             car_e_i,
   input  logic             emerg_i,
   output logic             not_r_o,
   output logic             c_and_l_o,
   output logic             en_s_o,
   output logic             l_or_notc_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int unsigned DebW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       code_q, code_d;
   logic             car_s1_q, car_s2_q;
   logic             car_q, car_d;
   logic [DebW-1:0]  deb_q, deb_d;
   logic [CNT_W-1:0] load_val;
   logic             preempt;

`ifdef EMERG_PREEMPT_EN
   logic em_s1_q, em_s2_q;

   // Two-flop synchronizer for the asynchronous emergency request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         em_s1_q <= 1'b0;
         em_s2_q <= 1'b0;
      end else begin
         em_s1_q <= emerg_i;
         em_s2_q <= em_s1_q;
      end
   end

   assign preempt = em_s2_q;
`else
   logic unused_emerg;
   assign unused_emerg = emerg_i;
   assign preempt      = 1'b0;
`endif

   // Reload value for the selected interval; a zero-length interval behaves as one tick.
   always_comb begin
      int unsigned t_sel;
      t_sel = T_YEL;
      unique case (s_ic_i)
         2'b00: t_sel = T_YEL;
         2'b01: t_sel = T_CLR;
         2'b10: t_sel = T_NGMIN;
         2'b11: t_sel = T_EGMAX;
         default: t_sel = T_YEL;
      endcase
      load_val = (t_sel == 0) ? '0 : CNT_W'(t_sel - 1);
   end

   // Sensor synchronizer plus registered debounce and FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         car_s1_q <= 1'b0;
         car_s2_q <= 1'b0;
         car_q    <= 1'b0;
         deb_q    <= '0;
         state_q  <= StIdle;
         cnt_q    <= '0;
         code_q   <= 2'b00;
      end else begin
         car_s1_q <= car_e_i;
         car_s2_q <= car_s1_q;
         car_q    <= car_d;
         deb_q    <= deb_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
      end
   end

   // Debounce: accept the synced sensor after DEB_TICKS consecutive disagreeing ticks.
   always_comb begin
      car_d = car_q;
      deb_d = deb_q;
      if (tick_i) begin
         if (car_s2_q != car_q) begin
            if (deb_q == DebW'(DEB_TICKS - 1)) begin
               car_d = car_s2_q;
               deb_d = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end else begin
            deb_d = '0;
         end
      end
   end

   // Interval FSM: a load (new phase) wins over any coincident tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      if (!en_ic_i) begin
         state_d = StIdle;
      end else if (state_q == StIdle || s_ic_i != code_q) begin
         state_d = StRun;
         code_d  = s_ic_i;
         cnt_d   = load_val;
      end else if (state_q == StRun) begin
         if (preempt && code_q[1]) begin
            state_d = StExpired;
            cnt_d   = '0;
         end else if (tick_i) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StExpired;
            end
         end
      end
   end

   // Status strobes decode registered state only, so no input reaches an output.
   assign en_s_o      = (state_q == StExpired) && (code_q == 2'b00);
   assign not_r_o     = (state_q == StExpired) && (code_q == 2'b01);
   assign c_and_l_o   = (state_q == StExpired) && (code_q == 2'b10) && car_q;
   assign l_or_notc_o = (code_q == 2'b11) && (state_q != StIdle)
                        && ((state_q == StExpired) || !car_q);
   assign busy_o      = (state_q == StRun);
   assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_phase_interval_timer.sv
// Self-checking bench for phase_interval_timer against a tick-counting reference model.
module tb_phase_interval_timer;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned DEB   = 3;
   localparam int          VW    = CNT_W + 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tick = 1'b0;
   logic [1:0]       s_ic = 2'b00;
   logic             en_ic = 1'b0;
   logic             car_e = 1'b0;
   logic             emerg = 1'b0;
   logic             not_r, c_and_l, en_s, l_or_notc, busy;
   logic [CNT_W-1:0] cnt;
   logic [VW-1:0]    obs;

   int n_checks = 0;
   int n_pass   = 0;

   phase_interval_timer dut (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .s_ic_i      (s_ic),
      .en_ic_i     (en_ic),
      .car_e_i     (car_e),
      .emerg_i     (emerg),
      .not_r_o     (not_r),
      .c_and_l_o   (c_and_l),
      .en_s_o      (en_s),
      .l_or_notc_o (l_or_notc),
      .busy_o      (busy),
      .cnt_o       (cnt)
   );

   always #5 clk = ~clk;

   assign obs = {busy, en_s, not_r, c_and_l, l_or_notc, cnt};

   // Reference model: phase described as ticks elapsed since load versus interval length.
   int t_tab [4] = '{5, 2, 10, 8};
   bit m_active;
   bit [1:0] m_code;
   int m_elapsed, m_len, m_cnt, m_diff;
   bit m_car;
   bit car_pipe[$];
   bit em_pipe[$];

   function automatic void model_reset();
      m_active = 0; m_code = 0; m_elapsed = 0; m_len = 1; m_cnt = 0;
      m_car = 0; m_diff = 0;
      car_pipe.delete(); car_pipe.push_back(1'b0); car_pipe.push_back(1'b0);
      em_pipe.delete();  em_pipe.push_back(1'b0);  em_pipe.push_back(1'b0);
   endfunction

   function automatic void model_edge();
      bit synced, em, pre;
      synced = car_pipe.pop_front();
      car_pipe.push_back(car_e);
      em = em_pipe.pop_front();
      em_pipe.push_back(emerg);
      pre = 1'b0;
`ifdef EMERG_PREEMPT_EN
      pre = em && m_code[1];
`else
      if (em) pre = 1'b0;
`endif
      if (tick) begin
         if (synced != m_car) begin
            m_diff++;
            if (m_diff == DEB) begin
               m_car  = synced;
               m_diff = 0;
            end
         end else begin
            m_diff = 0;
         end
      end
      if (!en_ic) begin
         m_active = 0;
      end else if (!m_active || s_ic != m_code) begin
         m_active  = 1;
         m_code    = s_ic;
         m_elapsed = 0;
         m_len     = (t_tab[s_ic] == 0) ? 1 : t_tab[s_ic];
      end else if (m_elapsed < m_len) begin
         if (pre) m_elapsed = m_len;
         else if (tick) m_elapsed++;
      end
      if (m_active) m_cnt = (m_elapsed >= m_len) ? 0 : m_len - 1 - m_elapsed;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      bit expired;
      logic e_busy, e_ens, e_notr, e_cl, e_lnc;
      expired = m_active && (m_elapsed >= m_len);
      e_busy  = m_active && !expired;
      e_ens   = expired && m_code == 2'd0;
      e_notr  = expired && m_code == 2'd1;
      e_cl    = expired && m_code == 2'd2 && m_car;
      e_lnc   = m_code == 2'd3 && m_active && (expired || !m_car);
      return {e_busy, e_ens, e_notr, e_cl, e_lnc, CNT_W'(m_cnt)};
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      model_reset();
      n_checks++;
      if (obs !== '0) $display("FAIL reset_state: got %h expected %h", obs, {VW{1'b0}});
      else n_pass++;
      step();
      rst = 1'b0;
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_clearance();
      int ticks, rise;
      ticks = 0; rise = -1;
      en_ic = 1'b1; s_ic = 2'b01;
      for (int i = 0; i < 20; i++) begin
         tick = (i % 4 == 3);
         step();
         if (tick) ticks++;
         if (not_r === 1'b1 && rise < 0) rise = ticks;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL clr_cycle%0d: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
      tick = 1'b0;
      n_checks++;
      if (rise !== 2 || not_r !== 1'b1)
         $display("FAIL clr_rise: got ticks=%0d not_r=%b expected ticks=2 not_r=1", rise, not_r);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      s_ic = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
      rst  = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (obs !== '0) $display("FAIL mid_reset: got %h expected %h", obs, {VW{1'b0}});
      else n_pass++;
      step();
      rst = 1'b0;
      step();
      n_checks++;
      if (obs !== exp_vec() || cnt !== 16'd9)
         $display("FAIL reload_after_reset: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_ngmin();
      int ticks, rise;
      bit seen;
      ticks = 0; rise = -1; seen = 0;
      en_ic = 1'b0;
      step();
      en_ic = 1'b1; s_ic = 2'b10; car_e = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick = (i % 2 == 1);
         step();
         if (tick) ticks++;
         if (c_and_l === 1'b1 && rise < 0) rise = ticks;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL ng_car%0d: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (rise !== 10) $display("FAIL ng_rise: got ticks=%0d expected 10", rise);
      else n_pass++;
      tick = 1'b0; en_ic = 1'b0;
      step();
      en_ic = 1'b1; car_e = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick = (i % 2 == 1);
         step();
         if (c_and_l === 1'b1) seen = 1;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL ng_nocar%0d: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
      tick = 1'b0;
      n_checks++;
      if (seen) $display("FAIL ng_nocar_cl: got c_and_l=1 expected 0 throughout");
      else n_pass++;
   endtask

   task automatic test_egmax();
      bit saw_low;
      saw_low = 0;
      s_ic = 2'b11; tick = 1'b0;
      step();
      n_checks++;
      if (l_or_notc !== 1'b1) $display("FAIL eg_load: got %b expected 1", l_or_notc);
      else n_pass++;
      car_e = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick = (i % 2 == 1);
         step();
         if (l_or_notc === 1'b0) saw_low = 1;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL eg_cycle%0d: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
      tick = 1'b0;
      n_checks++;
      if (!saw_low || l_or_notc !== 1'b1)
         $display("FAIL eg_sequence: got saw_low=%b final=%b expected 1 1", saw_low, l_or_notc);
      else n_pass++;
   endtask

   task automatic test_load_wins();
      s_ic = 2'b00; tick = 1'b0;
      step();
      tick = 1'b1;
      step();
      step();
      s_ic = 2'b01;
      step();
      n_checks++;
      if (cnt !== 16'd1 || obs !== exp_vec())
         $display("FAIL load_wins: got cnt=%0d obs=%h expected cnt=1 obs=%h", cnt, obs, exp_vec());
      else n_pass++;
      step();
      n_checks++;
      if (not_r !== 1'b0) $display("FAIL load_wins_t1: got not_r=%b expected 0", not_r);
      else n_pass++;
      step();
      tick = 1'b0;
      n_checks++;
      if (not_r !== 1'b1) $display("FAIL load_wins_t2: got not_r=%b expected 1", not_r);
      else n_pass++;
   endtask

   task automatic test_emerg();
      logic [CNT_W-1:0] want;
      s_ic = 2'b10; tick = 1'b0;
      step();
      tick = 1'b1;
      for (int i = 0; i < 3; i++) step();
      tick = 1'b0;
      n_checks++;
      if (cnt !== 16'd6) $display("FAIL em_precount: got %0d expected 6", cnt);
      else n_pass++;
      emerg = 1'b1;
      for (int i = 0; i < 3; i++) step();
      emerg = 1'b0;
`ifdef EMERG_PREEMPT_EN
      want = 16'd0;
`else
      want = 16'd6;
`endif
      n_checks++;
      if (cnt !== want || obs !== exp_vec())
         $display("FAIL em_preempt: got cnt=%0d obs=%h expected cnt=%0d obs=%h",
                  cnt, obs, want, exp_vec());
      else n_pass++;
      tick = 1'b1;
      step();
      tick = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL em_after: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         en_ic = ($urandom_range(19) != 0);
         if ($urandom_range(14) == 0) s_ic = 2'($urandom_range(3));
         tick  = ($urandom_range(2) == 0);
         if ($urandom_range(9) == 0) car_e = ~car_e;
         emerg = ($urandom_range(7) == 0);
         step();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL rand%0d: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clearance();
      test_mid_reset();
      test_ngmin();
      test_egmax();
      test_load_wins();
      test_emerg();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
